// File: rtl/load_store_pipe_arbiter_n.sv
// load_store_pipe_arbiter_n: N-channel arbiter onto one load/store pipe port, one transaction outstanding.
// Define LDST_ARB_TIMEOUT_EN to add a WAIT watchdog with oTIMEOUT/oTIMEOUT_CH outputs.
module load_store_pipe_arbiter_n #(
  parameter int P_CH = 2,
  parameter int P_ADDR_W = 32,
  parameter int P_DATA_W = 32,
  parameter int P_RR = 1,
  parameter int P_TIMEOUT = 1024,
  localparam int CW = $clog2(P_CH)
) (
  input  logic                     iCLOCK,
  input  logic                     iRESET_SYNC,
  input  logic                     iLOCK,
  input  logic [CW-1:0]            iLOCK_CH,
  input  logic [P_CH-1:0]          iCH_REQ,
  output logic [P_CH-1:0]          oCH_BUSY,
  input  logic [2*P_CH-1:0]        iCH_ORDER,
  input  logic [4*P_CH-1:0]        iCH_MASK,
  input  logic [P_CH-1:0]          iCH_RW,
  input  logic [P_ADDR_W*P_CH-1:0] iCH_ADDR,
  input  logic [P_DATA_W*P_CH-1:0] iCH_DATA,
  output logic [P_CH-1:0]          oCH_VALID,
  output logic                     oCH_CACHE_HIT,
  output logic [P_DATA_W-1:0]      oCH_DATA,
`ifdef LDST_ARB_TIMEOUT_EN
  output logic                     oTIMEOUT,
  output logic [CW-1:0]            oTIMEOUT_CH,
`endif
  output logic                     oLDST_REQ,
  input  logic                     iLDST_BUSY,
  output logic [1:0]               oLDST_ORDER,
  output logic [3:0]               oLDST_MASK,
  output logic                     oLDST_RW,
  output logic [P_ADDR_W-1:0]      oLDST_ADDR,
  output logic [P_DATA_W-1:0]      oLDST_DATA,
  input  logic                     iLDST_VALID,
  input  logic                     iLDST_CACHE_HIT,
  input  logic [P_DATA_W-1:0]      iLDST_DATA
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  localparam logic [P_CH-1:0] ONE = {{(P_CH-1){1'b0}}, 1'b1};
  state_t state_q, state_d;
  logic [CW-1:0] grant_q, grant_d, ptr_q, ptr_d, win;
  logic [P_CH-1:0] lock_oh, elig, capable;
  logic any_elig, accept, resp, to;
  logic [1:0] order_q, order_d;
  logic [3:0] mask_q, mask_d;
  logic rw_q, rw_d;
  logic [P_ADDR_W-1:0] addr_q, addr_d;
  logic [P_DATA_W-1:0] data_q, data_d;
  // An out-of-range lock index shifts the bit out, leaving nobody eligible.
  assign lock_oh = ONE << iLOCK_CH;
  assign elig = iLOCK ? (iCH_REQ & lock_oh) : iCH_REQ;
  assign capable = iLOCK ? lock_oh : '1;
  assign any_elig = |elig;
  assign accept = (state_q == IDLE) && any_elig;
  assign resp = (state_q == WAIT) && iLDST_VALID;
  // Scan from the far end so the last hit is the first index in priority order.
  always_comb begin
    int idx;
    idx = 0;
    win = '0;
    for (int k = P_CH - 1; k >= 0; k--) begin
      idx = (P_RR != 0) ? (int'(ptr_q) + 1 + k) % P_CH : k;
      if (elig[idx]) win = CW'(idx);
    end
  end
  always_comb begin
    state_d = accept ? ISSUE
            : (state_q == ISSUE && !iLDST_BUSY) ? WAIT
            : (resp || to) ? IDLE : state_q;
    grant_d = accept ? win : grant_q;
    ptr_d = (accept && P_RR != 0) ? win : ptr_q;
    order_d = accept ? iCH_ORDER[win*2 +: 2] : order_q;
    mask_d = accept ? iCH_MASK[win*4 +: 4] : mask_q;
    rw_d = accept ? iCH_RW[win] : rw_q;
    addr_d = accept ? iCH_ADDR[win*P_ADDR_W +: P_ADDR_W] : addr_q;
    data_d = accept ? iCH_DATA[win*P_DATA_W +: P_DATA_W] : data_q;
  end
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q <= CW'(P_CH - 1);
      order_q <= '0;
      mask_q <= '0;
      rw_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q <= ptr_d;
      order_q <= order_d;
      mask_q <= mask_d;
      rw_q <= rw_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end
`ifdef LDST_ARB_TIMEOUT_EN
  localparam int TW = $clog2(P_TIMEOUT) + 1;
  logic [TW-1:0] cnt_q;
  // Held at zero outside WAIT, so it reads zero on the first WAIT cycle.
  always_ff @(posedge iCLOCK) begin
    cnt_q <= (iRESET_SYNC || state_q != WAIT) ? '0 : cnt_q + 1'b1;
  end
  assign to = (state_q == WAIT) && !iLDST_VALID && (cnt_q == TW'(P_TIMEOUT - 1));
  assign oTIMEOUT = to;
  assign oTIMEOUT_CH = grant_q;
`else
  assign to = 1'b0;
`endif
  assign oCH_BUSY = (state_q != IDLE) ? '1 : any_elig ? ~(ONE << win) : ~capable;
  assign oCH_VALID = resp ? (ONE << grant_q) : '0;
  assign oCH_CACHE_HIT = iLDST_CACHE_HIT;
  assign oCH_DATA = iLDST_DATA;
  assign oLDST_REQ = (state_q == ISSUE);
  assign oLDST_ORDER = order_q;
  assign oLDST_MASK = mask_q;
  assign oLDST_RW = rw_q;
  assign oLDST_ADDR = addr_q;
  assign oLDST_DATA = data_q;
endmodule

// File: doc/load_store_pipe_arbiter_n.md
Name: load_store_pipe_arbiter_n

Overview:
- N-channel arbiter between load/store requesters (execution, exception, debug, etc.) and the single load/store pipe port.
- Registers the accepted request and keeps at most one transaction outstanding.
- Returns the response (VALID, data, cache-hit) only to the channel that issued it.
- Supports fixed-priority or round-robin arbitration, plus a lock input that restricts access to one channel (exception-handler ownership).

Parameters:
- P_CH, 2, number of requester channels (2..8).
- P_ADDR_W, 32, address width.
- P_DATA_W, 32, data width.
- P_RR, 1, 1 = round-robin arbitration; 0 = fixed priority, lowest index wins.
- P_TIMEOUT, 1024, watchdog limit in cycles (used only with the optional feature).

Ports:
- iCLOCK  in  1  clock.
- iRESET_SYNC  in  1  synchronous reset, active-high.
- iLOCK  in  1  when 1, only channel iLOCK_CH is eligible.
- iLOCK_CH  in  $clog2(P_CH)  locked channel index.
- iCH_REQ  in  P_CH  per-channel request.
- oCH_BUSY  out  P_CH  per-channel busy; a request is accepted when REQ=1 and BUSY=0.
- iCH_ORDER  in  2*P_CH  per-channel order: 00 byte, 01 2-byte, 10 word.
- iCH_MASK  in  4*P_CH  per-channel byte mask.
- iCH_RW  in  P_CH  per-channel direction: 0 read, 1 write.
- iCH_ADDR  in  P_ADDR_W*P_CH  per-channel address.
- iCH_DATA  in  P_DATA_W*P_CH  per-channel write data.
- oCH_VALID  out  P_CH  one-hot response strobe.
- oCH_CACHE_HIT  out  1  equals iLDST_CACHE_HIT; qualified by oCH_VALID.
- oCH_DATA  out  P_DATA_W  equals iLDST_DATA; qualified by oCH_VALID.
- oLDST_REQ  out  1  request to the load/store pipe.
- iLDST_BUSY  in  1  pipe busy.
- oLDST_ORDER  out  2  registered order.
- oLDST_MASK  out  4  registered mask.
- oLDST_RW  out  1  registered direction.
- oLDST_ADDR  out  P_ADDR_W  registered address.
- oLDST_DATA  out  P_DATA_W  registered write data.
- iLDST_VALID  in  1  pipe response strobe; every transaction, read or write, ends with one.
- iLDST_CACHE_HIT  in  1  pipe cache-hit flag.
- iLDST_DATA  in  P_DATA_W  pipe read data.

Behaviour:
- Reset values: state=IDLE, oLDST_REQ=0, all oLDST_* payload outputs=0, grant register=0, round-robin pointer=P_CH-1 (so channel 0 has priority first), oCH_VALID=0.
- Eligible set: iCH_REQ masked to bit iLOCK_CH when iLOCK=1.
- Winner, combinational and computed only in IDLE:
  - P_RR=0: lowest eligible index.
  - P_RR=1: first eligible index at or after pointer+1, wrapping modulo P_CH.
- oCH_BUSY[i]=0 only when state==IDLE and i is the winner, or when state==IDLE and no channel is eligible and i is eligible-capable (iLOCK=0 or i==iLOCK_CH). Otherwise 1.
- A losing requester sees BUSY=1 in the same cycle and must hold REQ and payload.
- IDLE -> ISSUE on acceptance:
  - Capture the winner's payload into the oLDST_* registers.
  - Grant register = winner.
  - Pointer = winner (P_RR=1).
- ISSUE:
  - oLDST_REQ=1 with stable payload.
  - When iLDST_BUSY=0 the pipe accepts; go to WAIT and drop oLDST_REQ next cycle.
- WAIT:
  - On iLDST_VALID=1: oCH_VALID[grant]=1 in the same cycle (combinational), go to IDLE.
  - New acceptance is possible on the following cycle at the earliest.
- Latency: accept at cycle T, oLDST_REQ at T+1; response strobe in the same cycle as iLDST_VALID.
- iLDST_VALID in IDLE or ISSUE: ignored, no oCH_VALID.
- Lock changes while not in IDLE do not abort the transaction; the response still goes to the captured grant channel.
- iLOCK_CH >= P_CH: no channel is eligible.
- Reset mid-transaction: returns to IDLE and drops the outstanding transaction. The downstream pipe must be reset in the same cycle.
- Back-to-back requests from the same channel under P_RR=1 alternate with any other pending channel.

Optional Feature:
- Macro LDST_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - On reaching P_TIMEOUT-1 without iLDST_VALID, the state goes to IDLE and extra outputs oTIMEOUT (1 bit, one-cycle pulse) and oTIMEOUT_CH (registered grant index) are driven.
  - No oCH_VALID is issued for the timed-out transaction.
  - A late iLDST_VALID is ignored.
- When undefined: no counter and no extra ports; WAIT persists indefinitely.

Test Plan:
- Single channel read, P_CH=2: ch0 REQ addr 0x100, iLDST_BUSY=0, iLDST_VALID 3 cycles later with data 0xDEADBEEF -> oLDST_REQ one cycle, oLDST_ADDR=0x100, oCH_VALID=2'b01 with oCH_DATA=0xDEADBEEF.
- Round-robin fairness, P_CH=4: all four REQ held, every response after 1 cycle -> grant order 0,1,2,3,0; oCH_BUSY one-hot-low only in IDLE.
- Fixed priority, P_RR=0: ch1 and ch2 request continuously -> ch1 wins every grant; ch2 starves while ch1 requests.
- Lock: iLOCK=1, iLOCK_CH=1, ch0 and ch1 requesting -> only ch1 granted; lock drops mid-WAIT -> ch1 still receives the VALID, then ch0 is granted.
- Backpressure: iLDST_BUSY=1 for 5 cycles during ISSUE -> oLDST_REQ and payload stable for all 5 cycles; stray iLDST_VALID in ISSUE produces no oCH_VALID.
- Timeout (LDST_ARB_TIMEOUT_EN, P_TIMEOUT=8): no VALID -> oTIMEOUT pulse with oTIMEOUT_CH=grant after 8 WAIT cycles, then IDLE; synchronous reset mid-WAIT returns all outputs to their reset values.
